// File: rtl/huffman_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : huffman_sequencer_if
// Brief    : Pair-buffer, LUT, code-handshake and status bundle of the sequencer.
// Revision : 1.0
// ============================================================================
interface huffman_sequencer_if;
    logic        start_in;
    logic [6:0]  num_pairs_in;
    logic        rd_en_out;
    logic [5:0]  rd_addr_out;
    logic [7:0]  rd_run_in;
    logic [7:0]  rd_size_in;
    logic [7:0]  lut_run_out;
    logic [7:0]  lut_size_out;
    logic [15:0] lut_code_in;
    logic [15:0] code_out;
    logic        code_valid_out;
    logic        code_ready_in;
    logic        busy_out;
    logic        done_out;
    logic        err_out;

    modport slave (
        input  start_in, num_pairs_in, rd_run_in, rd_size_in, lut_code_in, code_ready_in,
        output rd_en_out, rd_addr_out, lut_run_out, lut_size_out, code_out,
               code_valid_out, busy_out, done_out, err_out
    );

    modport master (
        output start_in, num_pairs_in, rd_run_in, rd_size_in, lut_code_in, code_ready_in,
        input  rd_en_out, rd_addr_out, lut_run_out, lut_size_out, code_out,
               code_valid_out, busy_out, done_out, err_out
    );
endinterface
`default_nettype wire

// File: rtl/huffman_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : huffman_sequencer
// Brief    : Walks one block of (run,size) pairs through the Huffman code LUT.
// Revision : 1.0
// ============================================================================
module huffman_sequencer #(
    parameter int MAX_PAIRS = 64
) (
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    huffman_sequencer_if.slave bus
);
    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_FETCH   = 3'd1;
    localparam logic [2:0] c_LOOKUP  = 3'd2;
    localparam logic [2:0] c_EMIT    = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;
    localparam logic [6:0] c_MAX_CNT = 7'(MAX_PAIRS);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [6:0]  r_cnt;
    logic [5:0]  r_idx;
    logic        r_eob;
    logic        r_err;
    logic [7:0]  r_lut_run;
    logic [7:0]  r_lut_size;
    logic [15:0] r_code;

    logic [6:0]  w_clamped;
    logic        w_legal;
    logic        w_is_eob;
    logic        w_last;

    assign w_clamped = (bus.num_pairs_in > c_MAX_CNT) ? c_MAX_CNT : bus.num_pairs_in;
    assign w_is_eob  = (bus.rd_run_in == 8'd0) && (bus.rd_size_in == 8'd0);
    // Zero size is only meaningful as EOB (0,0) or ZRL (15,0).
    assign w_legal   = (bus.rd_run_in <= 8'd15) && (bus.rd_size_in <= 8'd10) &&
                       ((bus.rd_size_in != 8'd0) || (bus.rd_run_in == 8'd0) ||
                        (bus.rd_run_in == 8'd15));
    assign w_last    = ({1'b0, r_idx} == (r_cnt - 7'd1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (bus.start_in) w_next = (w_clamped == 7'd0) ? c_DONE : c_FETCH;
            c_FETCH:  w_next = c_LOOKUP;
            c_LOOKUP: w_next = w_legal ? c_EMIT : c_DONE;
            c_EMIT:   if (bus.code_ready_in) w_next = (r_eob || w_last) ? c_DONE : c_FETCH;
            c_DONE:   w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt      <= 7'd0;
            r_idx      <= 6'd0;
            r_eob      <= 1'b0;
            r_err      <= 1'b0;
            r_lut_run  <= 8'd0;
            r_lut_size <= 8'd0;
            r_code     <= 16'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start_in) begin
                        r_cnt <= w_clamped;
                        r_idx <= 6'd0;
                        r_eob <= 1'b0;
                        r_err <= 1'b0;
                    end
                end
                c_LOOKUP: begin
                    r_lut_run  <= bus.rd_run_in;
                    r_lut_size <= bus.rd_size_in;
                    if (w_legal) begin
                        r_code <= bus.lut_code_in;
                        r_eob  <= w_is_eob;
                    end else begin
                        r_err  <= 1'b1;
                    end
                end
                c_EMIT: begin
                    if (bus.code_ready_in && !(r_eob || w_last)) begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // In LOOKUP the LUT sees the buffer data directly so the code lands in the same cycle.
    always_comb begin
        bus.rd_en_out      = (r_state == c_FETCH);
        bus.rd_addr_out    = r_idx;
        bus.lut_run_out    = r_lut_run;
        bus.lut_size_out   = r_lut_size;
        if (r_state == c_LOOKUP) begin
            bus.lut_run_out  = bus.rd_run_in;
            bus.lut_size_out = bus.rd_size_in;
        end
        bus.code_out       = r_code;
        bus.code_valid_out = (r_state == c_EMIT);
        bus.busy_out       = (r_state != c_IDLE);
        bus.done_out       = (r_state == c_DONE);
        bus.err_out        = r_err;
    end
endmodule
`default_nettype wire

// File: doc/huffman_sequencer.md
# huffman_sequencer

Controller that sequences the combinational (run,size) Huffman code LUT over one block of up to 64 entries. It fetches each (run,size) pair from a synchronous pair buffer and drives the pair into the LUT. It registers the returned code and presents it to the downstream bit packer with a valid/ready handshake. It stops at the programmed pair count or at the first end-of-block pair (0,0), and flags illegal pairs.

## Interface
- MAX_PAIRS, 64: maximum entries per block; the address width is 6 bits.
- clk_in  input  1  system clock; all state changes on its rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- start_in  input  1  begin a block; sampled only in IDLE.
- num_pairs_in  input  7  pair count, 0..64; latched on an accepted start; values above 64 are clamped to 64.
- rd_en_out  output  1  pair buffer read strobe.
- rd_addr_out  output  6  pair buffer address.
- rd_run_in  input  8  run value; valid the cycle after rd_en_out.
- rd_size_in  input  8  size value; valid the cycle after rd_en_out.
- lut_run_out  output  8  run value driven to the LUT.
- lut_size_out  output  8  size value driven to the LUT.
- lut_code_in  input  16  code returned by the LUT, combinational from lut_run_out and lut_size_out.
- code_out  output  16  registered Huffman code.
- code_valid_out  output  1  code_out is valid.
- code_ready_in  input  1  downstream accepts the code.
- busy_out  output  1  high in every state except IDLE.
- done_out  output  1  one-cycle pulse at the end of a block.
- err_out  output  1  sticky illegal-pair flag; cleared by the next accepted start.

## Operation
- The state machine has five states: IDLE, FETCH, LOOKUP, EMIT, DONE.
- IDLE:
  - When start_in=1: latch the clamped count into cnt, set idx=0, clear err_out.
  - If cnt=0, go to DONE; otherwise go to FETCH.
- FETCH:
  - rd_en_out=1 and rd_addr_out=idx, for exactly one cycle.
  - Go to LOOKUP.
- LOOKUP:
  - Register rd_run_in and rd_size_in into the LUT drive registers.
  - The LUT is driven and code_out is captured from lut_code_in, both inside LOOKUP, using a combinational bypass.
  - A pair is legal only when all three hold:
    - run ≤ 15;
    - size ≤ 10;
    - size=0 only for (0,0) EOB or (15,0) ZRL.
  - Illegal pair: set err_out=1, go to DONE, and emit nothing.
  - Legal pair: set the eob flag if the pair is (0,0), then go to EMIT.
- EMIT:
  - code_valid_out=1 and code_out is held stable until code_ready_in=1.
  - On the handshake, if eob=1 or idx=cnt-1, go to DONE.
  - Otherwise increment idx and go to FETCH.
- DONE:
  - done_out=1 for one cycle, then go to IDLE.
- start_in is ignored in every state except IDLE.
- There is no abort; only rst_in stops a block.
- ZRL (15,0) is emitted as a normal code and does not terminate the block.
- idx never wraps: the maximum is 63 and the block terminates there.

## Timing
- Reset values: rd_en_out=0, rd_addr_out=0, lut_run_out=0, lut_size_out=0, code_out=0, code_valid_out=0, busy_out=0, done_out=0, err_out=0; state=IDLE.
- Reset asserted mid-block returns everything to the reset values immediately. No done_out pulse is produced.
- Latency, with start_in accepted at edge 0:
  - rd_en_out is high in cycle 1.
  - LOOKUP occurs in cycle 2.
  - code_valid_out first goes high in cycle 3.
- Throughput with code_ready_in held at 1: one code per 3 cycles.
- Block with N pairs and no stalls:
  - done_out is asserted 3N+1 cycles after start.
  - busy_out is high for 3N+1 cycles.
- num_pairs_in=0: done_out in cycle 1, no reads, no codes.
- Handshake rules:
  - code_out and code_valid_out do not change while valid=1 and ready=0.
  - code_ready_in is ignored while valid=0.
  - code_valid_out=1 and code_ready_in=1 in the same cycle count as exactly one transfer.
- start_in held high through DONE is not accepted until the cycle after the return to IDLE.

## Test plan
- Single pair (0,1), num_pairs=1, ready held at 1:
  - one code 16'h0001 in cycle 3;
  - done_out in cycle 4;
  - rd_addr_out=0.
- Four pairs (0,2), (1,1), (15,0), (2,1), ready held at 1:
  - codes 16'h0004, 16'h000B, 16'h03FA, 16'h001A in cycles 3, 6, 9, 12;
  - done_out in cycle 13.
- EOB at index 2 with num_pairs=64:
  - exactly 3 codes, the last 16'h0000;
  - no read of address 3;
  - done_out follows the third handshake.
- Backpressure: code_ready_in held at 0 for 5 cycles on the first code:
  - code_out is held stable;
  - no further reads occur;
  - the second read issues the cycle after the handshake.
- Illegal pair (3,0) at index 1:
  - one code emitted;
  - err_out=1 and done_out pulse with no second code;
  - the next start clears err_out.
- Reset pulse during EMIT of code 5 of 64:
  - all outputs return to reset values asynchronously, without waiting for a clock edge;
  - no done_out pulse;
  - a new start restarts at rd_addr_out=0.
